pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
//
// PURPOSE
//   Parametrised, pipelined WIDTH-bit add/subtract unit built from half-adder slices.
//   Generalises the 1-bit half adder to multi-bit operands with carry-in, subtract mode,
//   carry-out and signed overflow, split over STAGES register stages.
//   Sits between an operand producer and a result consumer; both sides use valid/ready.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits; WIDTH >= 2
//   STAGES  2   pipeline stages = latency in cycles; 1 <= STAGES <= WIDTH; WIDTH % STAGES == 0
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand beat offered
//   in_ready   out  1      unit accepts beat this cycle
//   a          in   WIDTH  operand A (unsigned or two's complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (ignored when sub=1)
//   sub        in   1      0: a+b+cin   1: a-b (a + ~b + 1)
//   out_valid  out  1      result beat offered
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry-out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed overflow: (a_msb == b'_msb) && (sum_msb != a_msb), b' = sub ? ~b : b
//
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valids 0; out_valid=0, sum=0, cout=0, ovf=0.
//   - Transfer on in_valid&&in_ready (input), out_valid&&out_ready (output).
//   - Global advance enable: adv = !out_valid || out_ready; in_ready = adv (combinational).
//   - When adv=1 every stage register loads from its predecessor, stage 0 from inputs;
//     a bubble (in_valid=0) propagates as valid=0. When adv=0 whole pipe holds.
//   - Stage k adds bit slice [(k+1)*W/S-1 : k*W/S] using carry from stage k-1; higher
//     operand slices and lower result slices are carried forward (skewed pipeline).
//   - Latency: beat accepted in cycle n appears on out_valid in cycle n+STAGES if no stall.
//   - Throughput: one beat per cycle while out_ready=1.
//   - Outputs (sum/cout/ovf) stable while out_valid=1 and out_ready=0.
//   - sum/cout/ovf are don't-care when out_valid=0, but hold last value (no X).
//   - sub=1 overrides cin: carry into bit 0 is 1, B inverted at stage 0.
//   - Reset mid-operation: all in-flight beats discarded, no output produced for them.
//   - Simultaneous accept and emit in same cycle allowed (full pipe, out_ready=1).
//
// STRUCTURE
//   - Shared package/header: none required; WIDTH/STAGES sanity checks as elaboration-time
//     checks (generate-time $error or initial assertion) in this module.
//   - One sub-module: add_slice -- SW-bit ripple full-adder chain, each full adder built
//     from two ha instances plus OR; ports a, b, ci, s, co, plus MSB carry-in for ovf.
//   - Top: generate loop of STAGES add_slice instances + per-stage valid and data registers.
//
// TESTING (WIDTH=8, STAGES=2 unless noted)
//   1. a=0x0F b=0x01 cin=0 sub=0 -> 2 cycles later sum=0x10 cout=0 ovf=0.
//   2. a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 ovf=0; a=0x7F b=0x01 -> sum=0x80 ovf=1.
//   3. sub=1 a=0x05 b=0x07 cin=1 -> sum=0xFE cout=0 ovf=0; a=0x80 b=0x01 -> sum=0x7F ovf=1.
//   4. Stream 4 beats back-to-back, out_ready low for 3 cycles mid-stream -> in_ready=0
//      during stall, outputs held, all 4 results emitted in order, none lost/duplicated.
//   5. Assert rst with 2 beats in flight -> out_valid=0 next edge, no stale result after release.
//   6. Exhaustive 8-bit random vs reference model, STAGES in {1,2,4,8}; check sum/cout/ovf.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared types and configuration helpers for the pipelined add/subtract unit.
package pipelined_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STAGES = 2;

  // Per-stage control flags travelling alongside the data registers.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stage_ctl_t;

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_add_slice.sv
// SW-bit ripple adder slice; each full adder is two half adders plus an OR.
module pipelined_adder_add_slice #(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          cm
);

  logic [SW:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SW; i++) begin : g_fa
    logic p;
    logic g1;
    logic g2;

    pipelined_adder_ha u_ha0 (.a(a[i]), .b(b[i]), .s(p),    .c(g1));
    pipelined_adder_ha u_ha1 (.a(p),    .b(c[i]), .s(s[i]), .c(g2));

    assign c[i+1] = g1 | g2;
  end

  assign co = c[SW];
  // Carry into the slice MSB; combined with co it yields signed overflow.
  assign cm = c[SW-1];

endmodule

// File: rtl/pipelined_adder_ha.sv
// One-bit half adder: the primitive every full adder in the slice is built from.
module pipelined_adder_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/pipelined_adder.sv
// Skewed STAGES-deep add/subtract pipeline with a single global advance enable.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: need WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
  end

  logic             adv;
  logic [WIDTH-1:0] x_a [STAGES];
  logic [WIDTH-1:0] x_b [STAGES];
  logic [WIDTH-1:0] x_s [STAGES];
  logic [WIDTH-1:0] n_s [STAGES];
  logic             x_v [STAGES];
  logic             x_c [STAGES];
  logic [SW-1:0]    ss  [STAGES];
  logic             co  [STAGES];
  logic             cm  [STAGES];
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  stage_ctl_t       r_ctl [STAGES];

  // The whole pipe moves together whenever the output slot is free or draining.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << (k * SW);

    // Stage 0 takes the operands (B pre-inverted for subtract), later stages their predecessor.
    if (k == 0) begin : g_first
      assign x_a[k] = a;
      assign x_b[k] = sub ? ~b : b;
      assign x_c[k] = sub | cin;
      assign x_v[k] = in_valid;
      assign x_s[k] = '0;
    end else begin : g_next
      assign x_a[k] = r_a[k-1];
      assign x_b[k] = r_b[k-1];
      assign x_c[k] = r_ctl[k-1].carry;
      assign x_v[k] = r_ctl[k-1].valid;
      assign x_s[k] = r_s[k-1];
    end

    pipelined_adder_add_slice #(.SW(SW)) u_slice (
      .a  (x_a[k][k*SW +: SW]),
      .b  (x_b[k][k*SW +: SW]),
      .ci (x_c[k]),
      .s  (ss[k]),
      .co (co[k]),
      .cm (cm[k])
    );

    assign n_s[k] = (x_s[k] & ~MASK) | (WIDTH'(ss[k]) << (k * SW));
  end

  // Stage registers; the last one doubles as the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_ctl[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]         <= x_a[k];
        r_b[k]         <= x_b[k];
        r_s[k]         <= n_s[k];
        r_ctl[k].valid <= x_v[k];
        r_ctl[k].carry <= co[k];
        r_ctl[k].ovf   <= co[k] ^ cm[k];
      end
    end
  end

  assign out_valid = r_ctl[STAGES-1].valid;
  assign sum       = r_s[STAGES-1];
  assign cout      = r_ctl[STAGES-1].carry;
  assign ovf       = r_ctl[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on STAGES=2 plus scoreboarded random traffic on STAGES 1/2/4/8.
module tb_pipelined_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       drain_chk;

  logic       ir   [4];
  logic       ov   [4];
  logic       ordy [4];
  logic [7:0] sm   [4];
  logic       co_o [4];
  logic       of_o [4];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic ci, input logic sb);
    exp_t e;
    int   u;
    int   r;
    int   sx;
    int   sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      u   = int'(x) - int'(y);
      r   = sx - sy;
      e.c = (x >= y);
    end else begin
      u   = int'(x) + int'(y) + int'(ci);
      r   = sx + sy + int'(ci);
      e.c = (u > 255);
    end
    e.s = u[7:0];
    e.o = (r > 127) || (r < -128);
    return e;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_dut
    exp_t       q [$];
    exp_t       e;
    int         pops   = 0;
    logic       held_v = 1'b0;
    logic [7:0] held_s;
    logic       held_c;
    logic       held_o;

    pipelined_adder #(.WIDTH(8), .STAGES(32'(1) << i)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[i]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (ov[i]),
      .out_ready (ordy[i]),
      .sum       (sm[i]),
      .cout      (co_o[i]),
      .ovf       (of_o[i])
    );

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check($sformatf("s%0d_hold_valid", i), 32'(ov[i]), 32'(1));
          check($sformatf("s%0d_hold_sum", i), 32'(sm[i]), 32'(held_s));
          check($sformatf("s%0d_hold_cout", i), 32'(co_o[i]), 32'(held_c));
          check($sformatf("s%0d_hold_ovf", i), 32'(of_o[i]), 32'(held_o));
        end
        if (ov[i] && ordy[i]) begin
          if (q.size() == 0) begin
            check($sformatf("s%0d_spurious_out", i), 32'(1), 32'(0));
          end else begin
            e = q.pop_front();
            pops++;
            check($sformatf("s%0d_sum", i), 32'(sm[i]), 32'(e.s));
            check($sformatf("s%0d_cout", i), 32'(co_o[i]), 32'(e.c));
            check($sformatf("s%0d_ovf", i), 32'(of_o[i]), 32'(e.o));
          end
        end
        if (in_valid && ir[i]) q.push_back(model(a, b, cin, sub));
        held_v = ov[i] && !ordy[i];
        held_s = sm[i];
        held_c = co_o[i];
        held_o = of_o[i];
      end
    end

    always @(posedge drain_chk) check($sformatf("s%0d_drain_empty", i), 32'(q.size()), 32'(0));
  end

  function automatic logic [7:0] pick();
    logic [7:0] corner [5];
    corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return 8'($urandom_range(0, 255));
  endfunction

  // One beat through the STAGES=2 instance with an exact latency check.
  task automatic beat(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic tc, input logic ts,
                      input logic [7:0] es, input logic ec, input logic eo);
    in_valid = 1'b1;
    a = ta; b = tb_v; cin = tc; sub = ts;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 32'(ov[1]), 32'(0));
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(ov[1]), 32'(1));
    check({tag, "_sum"}, 32'(sm[1]), 32'(es));
    check({tag, "_cout"}, 32'(co_o[1]), 32'(ec));
    check({tag, "_ovf"}, 32'(of_o[1]), 32'(eo));
  endtask

  initial begin
    logic [7:0] sa [4];
    logic [7:0] sb [4];
    int         idx;
    int         base;
    logic       acc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; drain_chk = 1'b0;
    for (int i = 0; i < 4; i++) ordy[i] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s%0d_rst_out_valid", i), 32'(ov[i]), 32'(0));
      check($sformatf("s%0d_rst_sum", i), 32'(sm[i]), 32'(0));
      check($sformatf("s%0d_rst_cout", i), 32'(co_o[i]), 32'(0));
      check($sformatf("s%0d_rst_ovf", i), 32'(of_o[i]), 32'(0));
      check($sformatf("s%0d_rst_in_ready", i), 32'(ir[i]), 32'(1));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    beat("add_0f_01",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    beat("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    beat("add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    beat("add_cin",    8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    beat("sub_05_07",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    beat("sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;

    // Four back-to-back beats with a three-cycle consumer stall in the middle.
    sa = '{8'h11, 8'h22, 8'hF0, 8'h7F};
    sb = '{8'h01, 8'h02, 8'h20, 8'h7F};
    idx  = 0;
    base = g_dut[1].pops;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        a = sa[idx]; b = sb[idx];
      end
      cin = 1'b0; sub = 1'b0;
      ordy[1] = !(cyc >= 3 && cyc < 6);
      @(negedge clk);
      if (!ordy[1] && ov[1]) check("stall_in_ready", 32'(ir[1]), 32'(0));
      acc = in_valid && ir[1];
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    ordy[1]  = 1'b1;
    check("stream_beats_accepted", 32'(idx), 32'(4));
    check("stream_beats_emitted", 32'(g_dut[1].pops - base), 32'(4));

    // Reset with two beats in flight.
    in_valid = 1'b1; a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 8'h55; b = 8'h66;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_before_rst", 32'(ov[1]), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_out_valid", 32'(ov[1]), 32'(0));
    rst = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("s%0d_post_rst_idle", i), 32'(ov[i]), 32'(0));
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure on every instance.
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a   = pick();
      b   = pick();
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) ordy[i] = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) ordy[i] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    drain_chk = 1'b1;
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
